arm_cpu: RTL and testbench

- Single-cycle 32-bit ARMv4 subset processor core: data processing (ADD, SUB, AND, ORR), LDR/STR word, and B.
- Instruction and data memories are external. The core presents `pc` to the instruction memory and `alu_result`/`write_data`/`mem_write` to the data memory.
- Every instruction completes in one clock.
- Internally: controller (decoder, conditional logic, flags) and datapath (PC, 15-entry register file with R15 = PC+8, extender, ALU, result muxes).

---
 rtl/arm_cpu.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_arm_cpu.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/arm_cpu.sv
`default_nettype none
// ============================================================================
// Module   : arm_cpu
// Purpose  : Single-cycle 32-bit ARMv4 subset core. Supports data processing
//            (ADD, SUB, AND, ORR), LDR/STR word and B. Each instruction
//            completes in one clock. Instruction and data memories are
//            external and combinational.
// Ports    : clk        - system clock, all state updates on rising edge
//            reset      - asynchronous active-low reset (pc, NZCV)
//            instr      - instruction word fetched at pc
//            read_data  - data-memory read word (LDR)
//            mem_write  - data-memory write enable (executed STR only)
//            pc         - current program counter
//            write_data - store data (Rd value for STR)
//            alu_result - live ALU output, also data-memory address
// Revision : 1.0 - initial release
// ============================================================================
module arm_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] read_data,
    output logic        mem_write,
    output logic [31:0] pc,
    output logic [31:0] write_data,
    output logic [31:0] alu_result
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] c_OP_DP   = 2'b00;
    localparam logic [1:0] c_OP_MEM  = 2'b01;
    localparam logic [1:0] c_OP_BR   = 2'b10;

    localparam logic [3:0] c_CMD_AND = 4'b0000;
    localparam logic [3:0] c_CMD_SUB = 4'b0010;
    localparam logic [3:0] c_CMD_ADD = 4'b0100;
    localparam logic [3:0] c_CMD_ORR = 4'b1100;

    localparam logic [1:0] c_ALU_ADD = 2'd0;
    localparam logic [1:0] c_ALU_SUB = 2'd1;
    localparam logic [1:0] c_ALU_AND = 2'd2;
    localparam logic [1:0] c_ALU_ORR = 2'd3;

    localparam logic [3:0] c_R15     = 4'd15;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic        r_flag_n;
    logic        r_flag_z;
    logic        r_flag_c;
    logic        r_flag_v;
    logic [31:0] r_rf [0:14];

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic        w_imm_sel;
    logic [3:0]  w_cmd;
    logic        w_s_bit;
    logic        w_l_bit;
    logic        w_u_bit;
    logic [3:0]  w_rn;
    logic [3:0]  w_rd;
    logic [3:0]  w_rm;

    assign w_cond    = instr[31:28];
    assign w_op      = instr[27:26];
    assign w_imm_sel = instr[25];
    assign w_cmd     = instr[24:21];
    assign w_s_bit   = instr[20];
    assign w_l_bit   = instr[20];
    assign w_u_bit   = instr[23];
    assign w_rn      = instr[19:16];
    assign w_rd      = instr[15:12];
    assign w_rm      = instr[3:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic w_is_dp;
    logic w_is_mem;
    logic w_is_br;
    logic w_dp_valid;

    assign w_is_dp    = (w_op == c_OP_DP);
    assign w_is_mem   = (w_op == c_OP_MEM);
    assign w_is_br    = (w_op == c_OP_BR);
    // Unsupported DP commands decode as no-ops: no register or flag write.
    assign w_dp_valid = (w_cmd == c_CMD_ADD) || (w_cmd == c_CMD_SUB) ||
                        (w_cmd == c_CMD_AND) || (w_cmd == c_CMD_ORR);

    // ------------------------------------------------------------------
    // Condition check against the current NZCV (1111 behaves as AL)
    // ------------------------------------------------------------------
    logic w_cond_ok;

    always_comb begin
        w_cond_ok = 1'b1;
        case (w_cond)
            4'h0:    w_cond_ok = r_flag_z;
            4'h1:    w_cond_ok = ~r_flag_z;
            4'h2:    w_cond_ok = r_flag_c;
            4'h3:    w_cond_ok = ~r_flag_c;
            4'h4:    w_cond_ok = r_flag_n;
            4'h5:    w_cond_ok = ~r_flag_n;
            4'h6:    w_cond_ok = r_flag_v;
            4'h7:    w_cond_ok = ~r_flag_v;
            4'h8:    w_cond_ok = r_flag_c & ~r_flag_z;
            4'h9:    w_cond_ok = ~r_flag_c | r_flag_z;
            4'hA:    w_cond_ok = (r_flag_n == r_flag_v);
            4'hB:    w_cond_ok = (r_flag_n != r_flag_v);
            4'hC:    w_cond_ok = ~r_flag_z & (r_flag_n == r_flag_v);
            4'hD:    w_cond_ok = r_flag_z | (r_flag_n != r_flag_v);
            default: w_cond_ok = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Control signals, all gated by the condition check
    // ------------------------------------------------------------------
    logic w_reg_write;
    logic w_flag_write;
    logic w_branch;
    logic w_mem_write;

    assign w_reg_write  = w_cond_ok & ((w_is_dp & w_dp_valid) | (w_is_mem & w_l_bit));
    assign w_flag_write = w_cond_ok & w_is_dp & w_dp_valid & w_s_bit;
    assign w_branch     = w_cond_ok & w_is_br;
    assign w_mem_write  = w_cond_ok & w_is_mem & ~w_l_bit;

    // ------------------------------------------------------------------
    // Register file read ports; R15 reads return pc+8
    // ------------------------------------------------------------------
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;
    logic [3:0]  w_ra1;
    logic [3:0]  w_ra2;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;

    assign w_ra1 = w_is_br ? c_R15 : w_rn;
    // STR needs the data register on port 2; everything else reads Rm there.
    assign w_ra2 = (w_is_mem & ~w_l_bit) ? w_rd : w_rm;

    assign w_rd1 = (w_ra1 == c_R15) ? w_pc_plus8 : r_rf[w_ra1];
    assign w_rd2 = (w_ra2 == c_R15) ? w_pc_plus8 : r_rf[w_ra2];

    // ------------------------------------------------------------------
    // Operand extension
    // ------------------------------------------------------------------
    logic [31:0] w_src_b;

    always_comb begin
        w_src_b = w_rd2;
        case (w_op)
            c_OP_DP:  w_src_b = w_imm_sel ? {24'd0, instr[7:0]} : w_rd2;
            c_OP_MEM: w_src_b = {20'd0, instr[11:0]};
            c_OP_BR:  w_src_b = {{6{instr[23]}}, instr[23:0], 2'b00};
            default:  w_src_b = w_rd2;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU control: DP uses cmd, memory uses U to pick add/subtract,
    // branch adds the shifted offset to pc+8.
    // ------------------------------------------------------------------
    logic [1:0] w_alu_ctrl;

    always_comb begin
        w_alu_ctrl = c_ALU_ADD;
        if (w_is_dp) begin
            case (w_cmd)
                c_CMD_SUB: w_alu_ctrl = c_ALU_SUB;
                c_CMD_AND: w_alu_ctrl = c_ALU_AND;
                c_CMD_ORR: w_alu_ctrl = c_ALU_ORR;
                default:   w_alu_ctrl = c_ALU_ADD;
            endcase
        end else if (w_is_mem) begin
            w_alu_ctrl = w_u_bit ? c_ALU_ADD : c_ALU_SUB;
        end
    end

    // ------------------------------------------------------------------
    // ALU. Subtract is a + ~b + 1 so the carry out is the ARM NOT-borrow.
    // ------------------------------------------------------------------
    logic        w_sub;
    logic [31:0] w_b_eff;
    logic [32:0] w_sum;
    logic [31:0] w_alu;
    logic        w_alu_c;
    logic        w_alu_v;
    logic        w_arith;

    assign w_sub   = (w_alu_ctrl == c_ALU_SUB);
    assign w_arith = (w_alu_ctrl == c_ALU_ADD) || (w_alu_ctrl == c_ALU_SUB);
    assign w_b_eff = w_sub ? ~w_src_b : w_src_b;
    assign w_sum   = {1'b0, w_rd1} + {1'b0, w_b_eff} + {32'd0, w_sub};

    always_comb begin
        w_alu = w_sum[31:0];
        case (w_alu_ctrl)
            c_ALU_AND: w_alu = w_rd1 & w_src_b;
            c_ALU_ORR: w_alu = w_rd1 | w_src_b;
            default:   w_alu = w_sum[31:0];
        endcase
    end

    assign w_alu_c = w_sum[32];
    // Overflow: operands of equal sign produce a result of the other sign.
    assign w_alu_v = (w_rd1[31] == w_b_eff[31]) && (w_sum[31] != w_rd1[31]);

    // ------------------------------------------------------------------
    // Result selection and next PC
    // ------------------------------------------------------------------
    logic [31:0] w_result;
    logic [31:0] w_pc_next;

    assign w_result = w_is_mem ? read_data : w_alu;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_branch) begin
            w_pc_next = w_alu;
        end else if (w_reg_write && (w_rd == c_R15)) begin
            w_pc_next = w_result;
        end
    end

    // ------------------------------------------------------------------
    // PC and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= 32'd0;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_flag_write) begin
                r_flag_n <= w_alu[31];
                r_flag_z <= (w_alu == 32'd0);
                // Logical ops leave C and V untouched.
                if (w_arith) begin
                    r_flag_c <= w_alu_c;
                    r_flag_v <= w_alu_v;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file R0-R14 (not reset); Rd=15 is routed to the PC instead
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_reg_write && (w_rd != c_R15)) begin
            r_rf[w_rd] <= w_result;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc         = r_pc;
    assign alu_result = w_alu;
    assign write_data = w_rd2;
    assign mem_write  = w_mem_write;

endmodule
`default_nettype wire

// File: tb/tb_arm_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_cpu
// Purpose  : Directed self-checking bench for arm_cpu. Drives an instruction
//            stream with hand-computed pc, alu_result and mem_write values.
//            Register and flag contents are observed through readback
//            instructions and conditional branches.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] read_data;
    logic        mem_write;
    logic [31:0] pc;
    logic [31:0] write_data;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_errors = 0;

    arm_cpu dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .read_data  (read_data),
        .mem_write  (mem_write),
        .pc         (pc),
        .write_data (write_data),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one instruction, check combinational outputs, clock it, check pc.
    task automatic run(input string tag, input logic [31:0] i, input logic [31:0] rd,
                       input logic exp_mw, input bit chk_alu, input logic [31:0] exp_alu,
                       input logic [31:0] exp_pc);
        instr     = i;
        read_data = rd;
        #1;
        chk({tag, "_mw"}, {31'd0, mem_write}, {31'd0, exp_mw});
        if (chk_alu) chk({tag, "_alu"}, alu_result, exp_alu);
        @(posedge clk);
        #1;
        chk({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        reset     = 1'b0;
        instr     = 32'd0;
        read_data = 32'd0;
        #2;
        chk("reset_pc", pc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_pc", pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Loads, store, basic data processing
        run("ldr_r0", 32'hE41E0000, 32'hFFFFFFFF, 1'b0, 0, 32'd0, 32'd4);
        run("ldr_r1", 32'hE41E1000, 32'h000000FF, 1'b0, 0, 32'd0, 32'd8);
        instr = 32'hE4010000;  // STR R0,[R1]
        #1;
        chk("str_wdata", write_data, 32'hFFFFFFFF);
        run("str",    32'hE4010000, 32'd0, 1'b1, 1, 32'h000000FF, 32'd12);
        run("add",    32'hE0812001, 32'd0, 1'b0, 1, 32'h000001FE, 32'd16);
        run("sub",    32'hE0423001, 32'd0, 1'b0, 1, 32'h000000FF, 32'd20);
        run("and",    32'hE0034002, 32'd0, 1'b0, 1, 32'h000000FE, 32'd24);
        run("orr",    32'hE1835002, 32'd0, 1'b0, 1, 32'h000001FF, 32'd28);
        // Branch to self (offset -8 cancels pc+8)
        run("b_self", 32'hEAFFFFFE, 32'd0, 1'b0, 1, 32'd28,       32'd28);
        // Flags via SUBS then conditional ADDs
        run("and_imm", 32'hE2018055, 32'd0, 1'b0, 1, 32'h00000055, 32'd32);
        run("subs",    32'hE0516001, 32'd0, 1'b0, 1, 32'h00000000, 32'd36);
        run("addeq",   32'h02817001, 32'd0, 1'b0, 1, 32'h00000100, 32'd40);
        run("addne",   32'h12818001, 32'd0, 1'b0, 1, 32'h00000100, 32'd44);
        run("rb_r7",   32'hE2879000, 32'd0, 1'b0, 1, 32'h00000100, 32'd48);
        run("rb_r8",   32'hE2889000, 32'd0, 1'b0, 1, 32'h00000055, 32'd52);
        run("beq_z1",  32'h0A000000, 32'd0, 1'b0, 1, 32'd60,       32'd60);
        run("bcs_c1",  32'h2A000000, 32'd0, 1'b0, 0, 32'd0,        32'd68);
        run("bmi_n0",  32'h4A000000, 32'd0, 1'b0, 0, 32'd0,        32'd72);
        run("strne",   32'h14010000, 32'd0, 1'b0, 0, 32'd0,        32'd76);
        // Unsigned carry without overflow: FFFFFFFF + FF
        run("adds_c",  32'hE0909001, 32'd0, 1'b0, 1, 32'h000000FE, 32'd80);
        run("bne_z0",  32'h1A000000, 32'd0, 1'b0, 0, 32'd0,        32'd88);
        run("bvs_v0",  32'h6A000000, 32'd0, 1'b0, 0, 32'd0,        32'd92);
        // Signed overflow: 7FFFFFFF + 1
        run("ldr_r10", 32'hE41EA000, 32'h7FFFFFFF, 1'b0, 0, 32'd0, 32'd96);
        run("adds_v",  32'hE29AB001, 32'd0, 1'b0, 1, 32'h80000000, 32'd100);
        run("bvs_v1",  32'h6A000000, 32'd0, 1'b0, 0, 32'd0,        32'd108);
        run("bcs_c0",  32'h2A000000, 32'd0, 1'b0, 0, 32'd0,        32'd112);
        run("bge",     32'hAA000000, 32'd0, 1'b0, 0, 32'd0,        32'd120);
        run("bmi_n1",  32'h4A000000, 32'd0, 1'b0, 0, 32'd0,        32'd128);
        // ANDS updates N,Z only; C=0, V=1 must survive
        run("ands",    32'hE21AC000, 32'd0, 1'b0, 1, 32'h00000000, 32'd132);
        run("bvs_keep", 32'h6A000000, 32'd0, 1'b0, 0, 32'd0,       32'd140);
        run("bcc_keep", 32'h3A000000, 32'd0, 1'b0, 0, 32'd0,       32'd148);
        // Unsupported cmd with S=1: no flag or register write
        run("eors",    32'hE2319001, 32'd0, 1'b0, 0, 32'd0,        32'd152);
        run("beq_keep", 32'h0A000000, 32'd0, 1'b0, 0, 32'd0,       32'd160);
        run("rb_r9",   32'hE289D000, 32'd0, 1'b0, 1, 32'h000000FE, 32'd164);
        run("b_nv",    32'hFA000000, 32'd0, 1'b0, 0, 32'd0,        32'd172);
        run("blt",     32'hBA000000, 32'd0, 1'b0, 0, 32'd0,        32'd180);
        // Writes to R15
        run("add_pc",  32'hE28FF000, 32'd0, 1'b0, 1, 32'd188,      32'd188);
        run("ldr_pc",  32'hE41EF000, 32'h00000100, 1'b0, 0, 32'd0, 32'h00000100);

        // Asynchronous reset between edges
        instr = 32'hE0812001;
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_pc", pc, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_held_pc", pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run("b_fwd",   32'hEA000001, 32'd0, 1'b0, 1, 32'd12,       32'd12);
        run("beq_clr", 32'h0A000000, 32'd0, 1'b0, 0, 32'd0,        32'd16);
        run("bcc_clr", 32'h3A000000, 32'd0, 1'b0, 0, 32'd0,        32'd24);
        run("bvs_clr", 32'h6A000000, 32'd0, 1'b0, 0, 32'd0,        32'd28);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
